// File: rtl/warmboot_sequencer.sv
// Warm-boot hand-off sequencer between the bootloader and SB_WARMBOOT: detach USB, settle S1/S0, pulse BOOT.
// Optional idle auto-boot is built only when BOOT_IDLE_TIMEOUT_EN is defined.
//
//  state  | meaning
//  IDLE   | waiting for a boot_req rising edge (or idle timeout)
//  DETACH | USB detached, host sees disconnect
//  SETUP  | S1/S0 driven with latched image, BOOT low
//  FIRE   | BOOT pulse high
//  HOLD   | terminal, S1/S0 and detach held until reset
module warmboot_sequencer #(
   parameter int         DETACH_CYCLES       = 480000,
   parameter int         SETUP_CYCLES        = 16,
   parameter int         BOOT_PULSE_CYCLES   = 4,
   parameter int         IDLE_TIMEOUT_CYCLES = 48000000,
   parameter logic [1:0] TIMEOUT_IMAGE       = 2'b01
) (
   input  logic       clk_48mhz,
   input  logic       reset_n,
   input  logic       boot_req,
   input  logic [1:0] image_sel,
   input  logic       usb_activity,
   output logic       usb_detach,
   output logic       wb_s1,
   output logic       wb_s0,
   output logic       wb_boot,
   output logic       busy
);

   localparam int MAX_A   = (DETACH_CYCLES > SETUP_CYCLES) ? DETACH_CYCLES : SETUP_CYCLES;
   localparam int MAX_B   = (BOOT_PULSE_CYCLES > IDLE_TIMEOUT_CYCLES) ? BOOT_PULSE_CYCLES : IDLE_TIMEOUT_CYCLES;
   localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;

   localparam logic [CNT_W-1:0] DETACH_LOAD = CNT_W'(DETACH_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(BOOT_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   if (DETACH_CYCLES < 1 || SETUP_CYCLES < 1 || BOOT_PULSE_CYCLES < 1 || IDLE_TIMEOUT_CYCLES < 1)
   begin : g_bad_param
      $error("warmboot_sequencer: cycle parameters must be >= 1");
   end

   typedef enum logic [2:0] {S_IDLE, S_DETACH, S_SETUP, S_FIRE, S_HOLD} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [1:0]       sel_q, sel_nxt;
   logic             req_prev;
   logic             accept_req, start;
   logic [1:0]       start_sel;
   logic             detach_d, s1_d, s0_d, boot_d, busy_d;

   // req_prev resets high so a request already asserted at reset release is not an edge
   assign accept_req = boot_req & ~req_prev & (state == S_IDLE);

`ifdef BOOT_IDLE_TIMEOUT_EN
   localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] idle_cnt, idle_nxt;
   logic             idle_expire;

   assign idle_expire = (state == S_IDLE) && (idle_cnt == '0);
   assign start       = accept_req | idle_expire;
   assign start_sel   = accept_req ? image_sel : TIMEOUT_IMAGE;

   always_comb begin
      idle_nxt = idle_cnt;
      if (state == S_IDLE) begin
         if (usb_activity)
            idle_nxt = IDLE_LOAD;
         else if (idle_cnt != '0)
            idle_nxt = idle_cnt - CNT_ONE;
      end
   end

   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n)
         idle_cnt <= IDLE_LOAD;
      else
         idle_cnt <= idle_nxt;
   end
`else
   logic [2:0] unused_cfg;
   assign unused_cfg = {usb_activity, TIMEOUT_IMAGE};
   assign start      = accept_req;
   assign start_sel  = image_sel;
`endif

   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         sel_q      <= 2'b00;
         req_prev   <= 1'b1;
         usb_detach <= 1'b0;
         wb_s1      <= 1'b0;
         wb_s0      <= 1'b0;
         wb_boot    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         sel_q      <= sel_nxt;
         req_prev   <= boot_req;
         usb_detach <= detach_d;
         wb_s1      <= s1_d;
         wb_s0      <= s0_d;
         wb_boot    <= boot_d;
         busy       <= busy_d;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sel_nxt   = sel_q;
      case (state)
         S_IDLE: begin
            if (start) begin
               sel_nxt   = start_sel;
               cnt_nxt   = DETACH_LOAD;
               state_nxt = S_DETACH;
            end
         end
         S_DETACH: begin
            if (cnt == '0) begin
               cnt_nxt   = SETUP_LOAD;
               state_nxt = S_SETUP;
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         S_SETUP: begin
            if (cnt == '0) begin
               cnt_nxt   = PULSE_LOAD;
               state_nxt = S_FIRE;
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         S_FIRE: begin
            if (cnt == '0)
               state_nxt = S_HOLD;
            else
               cnt_nxt = cnt - CNT_ONE;
         end
         S_HOLD:  state_nxt = S_HOLD;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs decode the current state and are registered, so they trail state by one cycle
   always_comb begin
      detach_d = (state != S_IDLE);
      busy_d   = (state != S_IDLE);
      boot_d   = (state == S_FIRE);
      s1_d     = 1'b0;
      s0_d     = 1'b0;
      if (state == S_SETUP || state == S_FIRE || state == S_HOLD) begin
         s1_d = sel_q[1];
         s0_d = sel_q[0];
      end
   end

endmodule

// File: tb/tb_warmboot_sequencer.sv
// Self-checking bench for warmboot_sequencer: timeline model plus directed literal checks.
// Build with BOOT_IDLE_TIMEOUT_EN defined to exercise the auto-boot path.
module tb_warmboot_sequencer;

   localparam int         D  = 8;
   localparam int         S  = 2;
   localparam int         P  = 3;
   localparam int         T  = 20;
   localparam logic [1:0] TI = 2'b01;

   logic       clk_48mhz = 1'b0;
   logic       reset_n;
   logic       boot_req;
   logic [1:0] image_sel;
   logic       usb_activity;
   logic       usb_detach, wb_s1, wb_s0, wb_boot, busy;

   int n_checks;
   int n_fail;
   int boot_rises;
   int base;
   int k;
   logic boot_prev;

   // model state: edge index since reset release, edge of accepted request (-1 none)
   int         cyc;
   int         acc;
   int         reload_edge;
   logic       m_prev;
   logic [1:0] m_sel;

   warmboot_sequencer #(
      .DETACH_CYCLES      (D),
      .SETUP_CYCLES       (S),
      .BOOT_PULSE_CYCLES  (P),
      .IDLE_TIMEOUT_CYCLES(T),
      .TIMEOUT_IMAGE      (TI)
   ) dut (
      .clk_48mhz   (clk_48mhz),
      .reset_n     (reset_n),
      .boot_req    (boot_req),
      .image_sel   (image_sel),
      .usb_activity(usb_activity),
      .usb_detach  (usb_detach),
      .wb_s1       (wb_s1),
      .wb_s0       (wb_s0),
      .wb_boot     (wb_boot),
      .busy        (busy)
   );

   always #5 clk_48mhz = ~clk_48mhz;

   always @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         cyc         = 0;
         acc         = -1;
         reload_edge = 0;
         m_prev      = 1'b1;
         m_sel       = 2'b00;
      end else begin
         cyc = cyc + 1;
         if (acc < 0) begin
            if (boot_req && !m_prev) begin
               acc   = cyc;
               m_sel = image_sel;
            end
`ifdef BOOT_IDLE_TIMEOUT_EN
            else if (cyc - reload_edge == T) begin
               acc   = cyc;
               m_sel = TI;
            end
            if (usb_activity) reload_edge = cyc;
`endif
         end
         m_prev = boot_req;
      end
   end

   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic compare_model();
      logic       e_det, e_boot;
      logic [1:0] e_s;
      e_det  = 1'b0;
      e_boot = 1'b0;
      e_s    = 2'b00;
      if (reset_n && acc >= 0) begin
         e_det  = (cyc >= acc + 1);
         e_s    = (cyc >= acc + 1 + D) ? m_sel : 2'b00;
         e_boot = (cyc >= acc + 1 + D + S) && (cyc < acc + 1 + D + S + P);
      end
      chk("model_usb_detach", {1'b0, usb_detach}, {1'b0, e_det});
      chk("model_busy",       {1'b0, busy},       {1'b0, e_det});
      chk("model_s1s0",       {wb_s1, wb_s0},     e_s);
      chk("model_wb_boot",    {1'b0, wb_boot},    {1'b0, e_boot});
      if (wb_boot && !boot_prev) boot_rises++;
      boot_prev = wb_boot;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk_48mhz);
         compare_model();
      end
   endtask

   task automatic do_reset();
      #2 reset_n = 1'b0;
      step(2);
      #2 reset_n = 1'b1;
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      boot_rises   = 0;
      boot_prev    = 1'b0;
      reset_n      = 1'b0;
      boot_req     = 1'b0;
      image_sel    = 2'b00;
      usb_activity = 1'b0;
      step(3);
      chk("reset_busy",   {1'b0, busy},       2'b00);
      chk("reset_detach", {1'b0, usb_detach}, 2'b00);
      chk("reset_s1s0",   {wb_s1, wb_s0},     2'b00);
      #2 reset_n = 1'b1;

      // basic sequence with freezing of image_sel and a re-pulsed request during DETACH
      step(2);
      image_sel = 2'b10;
      boot_req  = 1'b1;
      k    = cyc + 1;
      base = boot_rises;
      step(1);
      chk("t1_detach_at_k",  {1'b0, usb_detach}, 2'b00);
      step(1);
      chk("t1_detach_k1",    {1'b0, usb_detach}, 2'b01);
      chk("t1_busy_k1",      {1'b0, busy},       2'b01);
      step(2);
      image_sel = 2'b11;
      boot_req  = 1'b0;
      step(1);
      boot_req  = 1'b1;
      step(4);
      chk("t1_s1s0_k8",      {wb_s1, wb_s0},     2'b00);
      step(1);
      chk("t1_s1s0_k9",      {wb_s1, wb_s0},     2'b10);
      step(1);
      chk("t1_boot_k10",     {1'b0, wb_boot},    2'b00);
      step(1);
      chk("t1_boot_k11",     {1'b0, wb_boot},    2'b01);
      step(2);
      chk("t1_boot_k13",     {1'b0, wb_boot},    2'b01);
      step(1);
      chk("t1_boot_k14",     {1'b0, wb_boot},    2'b00);
      chk("t1_detach_k14",   {1'b0, usb_detach}, 2'b01);
      step(10);
      chk("t2_s1s0_frozen",  {wb_s1, wb_s0},     2'b10);
      chk("t2_detach_hold",  {1'b0, usb_detach}, 2'b01);
      chk("t2_pulse_count",  2'(boot_rises - base), 2'd1);

      // reset during FIRE, then boot_req held high across release
      boot_req = 1'b0;
      do_reset();
      step(2);
      image_sel = 2'b01;
      boot_req  = 1'b1;
      k = cyc + 1;
      step(12);
      chk("t3_in_fire",      {1'b0, wb_boot},    2'b01);
      #2 reset_n = 1'b0;
      #1;
      chk("t3_async_detach", {1'b0, usb_detach}, 2'b00);
      chk("t3_async_boot",   {1'b0, wb_boot},    2'b00);
      chk("t3_async_s1s0",   {wb_s1, wb_s0},     2'b00);
      chk("t3_async_busy",   {1'b0, busy},       2'b00);
      step(2);
      #2 reset_n = 1'b1;
      step(15);
      chk("t3_no_start",     {1'b0, busy},       2'b00);
      boot_req = 1'b0;
      step(1);
      boot_req  = 1'b1;
      image_sel = 2'b10;
      k    = cyc + 1;
      base = boot_rises;
      step(2);
      chk("t3_restart_busy", {1'b0, busy},       2'b01);
      step(14);
      chk("t3_s1s0",         {wb_s1, wb_s0},     2'b10);
      chk("t3_pulse_count",  2'(boot_rises - base), 2'd1);

`ifdef BOOT_IDLE_TIMEOUT_EN
      // auto-boot after T idle cycles
      boot_req  = 1'b0;
      image_sel = 2'b00;
      base = boot_rises;
      do_reset();
      step(20);
      chk("t4_detach_c20",   {1'b0, usb_detach}, 2'b00);
      step(1);
      chk("t4_detach_c21",   {1'b0, usb_detach}, 2'b01);
      step(15);
      chk("t4_s1s0",         {wb_s1, wb_s0},     2'b01);
      chk("t4_pulse_count",  2'(boot_rises - base), 2'd1);

      // regular activity keeps the timer from expiring
      do_reset();
      for (int i = 0; i < 10; i++) begin
         usb_activity = 1'b1;
         step(1);
         usb_activity = 1'b0;
         step(9);
      end
      step(5);
      chk("t4_activity_busy", {1'b0, busy},      2'b00);

      // request edge on the expiry edge wins over the timeout image
      image_sel = 2'b11;
      boot_req  = 1'b0;
      do_reset();
      base = boot_rises;
      step(19);
      boot_req = 1'b1;
      step(2);
      chk("t5_detach_c21",   {1'b0, usb_detach}, 2'b01);
      step(15);
      chk("t5_s1s0",         {wb_s1, wb_s0},     2'b11);
      chk("t5_pulse_count",  2'(boot_rises - base), 2'd1);
`else
      // no timer built: a long idle stretch never starts a sequence
      boot_req  = 1'b0;
      image_sel = 2'b00;
      do_reset();
      step(1000);
      chk("t6_busy",         {1'b0, busy},       2'b00);
      chk("t6_detach",       {1'b0, usb_detach}, 2'b00);
      chk("t6_s1s0",         {wb_s1, wb_s0},     2'b00);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
